// File: rtl/zbt_arbiter_f_pkg.sv
// Shared constants and types for the ZBT arbiter/sequencer slice.
package zbt_arbiter_f_pkg;

    localparam int ZBT_DATA_BITS = 36;
    localparam int ZBT_ADDR_BITS = 19;
    localparam int ZBT_READ_LAT  = 4;

    // Requester identity carried alongside each access through the read pipe
    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    // One read-return tag: valid marks a read slot, owner picks the rvalid line
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/zbt_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, one pointer flop.
module zbt_rr_arb2
    import zbt_arbiter_f_pkg::*;
(
    input  logic       fpga_clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Requester that wins when both ask in the same cycle
    owner_e prio;

    // Grant selection; nothing is granted while reset is asserted
    always_comb begin
        gnt = '0;
        if (reset_n) begin
            if (req == 2'b11) begin
                gnt = (prio == OWNER_B) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Hand priority to the requester that was not just served
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= OWNER_A;
        end else if (gnt[0]) begin
            prio <= OWNER_B;
        end else if (gnt[1]) begin
            prio <= OWNER_A;
        end
    end

endmodule

// File: rtl/zbt_arbiter_f.sv
// Two-requester arbiter/sequencer in front of the flow-through ZBT datapath
// stage: issues one SRAM access per cycle and routes read data back.
module zbt_arbiter_f
    import zbt_arbiter_f_pkg::*;
#(
    parameter int DATA_BITS = ZBT_DATA_BITS,
    parameter int ADDR_BITS = ZBT_ADDR_BITS,
    parameter int READ_LAT  = ZBT_READ_LAT
) (
    input  logic                 fpga_clk,
    input  logic                 reset_n,
    input  logic                 a_req,
    input  logic                 a_rw_n,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [DATA_BITS-1:0] a_wdata,
    input  logic                 b_req,
    input  logic                 b_rw_n,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [DATA_BITS-1:0] b_wdata,
    output logic                 a_gnt,
    output logic                 b_gnt,
    output logic                 a_rvalid,
    output logic                 b_rvalid,
    output logic [DATA_BITS-1:0] rdata,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic                 sram_adv_ld_n,
    output logic                 sram_we_n,
    output logic                 sram_ce_n,
    output logic                 ui_rw_n,
    output logic [DATA_BITS-1:0] ui_write_data,
    input  logic [DATA_BITS-1:0] ui_read_data
);

    localparam int PIPE_LEN = READ_LAT - 1;

    logic [1:0]           gnt_vec;
    logic                 gnt_any;
    logic                 sel_rw_n;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [DATA_BITS-1:0] sel_wdata;
    owner_e               sel_owner;

    logic                 wr_q;
    logic [DATA_BITS-1:0] wdata_q;

    // The rvalid/rdata register is the final stage of the READ_LAT-deep tag
    // pipe, so only READ_LAT-1 stages live in this array.
    tag_t                 tag_pipe [PIPE_LEN];

    zbt_rr_arb2 u_arb (
        .fpga_clk (fpga_clk),
        .reset_n  (reset_n),
        .req      ({b_req, a_req}),
        .gnt      (gnt_vec)
    );

    assign a_gnt   = gnt_vec[0];
    assign b_gnt   = gnt_vec[1];
    assign gnt_any = |gnt_vec;

    // Mux the winning requester's command fields
    always_comb begin
        sel_rw_n  = a_rw_n;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        sel_owner = OWNER_A;
        if (gnt_vec[1]) begin
            sel_rw_n  = b_rw_n;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
            sel_owner = OWNER_B;
        end
    end

    // SRAM command pins: load the granted access, otherwise deselect
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_ce_n     <= 1'b1;
            sram_adv_ld_n <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_addr     <= '0;
        end else if (gnt_any) begin
            sram_ce_n     <= 1'b0;
            sram_adv_ld_n <= 1'b0;
            sram_we_n     <= sel_rw_n;
            sram_addr     <= sel_addr;
        end else begin
            sram_ce_n     <= 1'b1;
            sram_adv_ld_n <= 1'b1;
            sram_we_n     <= 1'b1;
        end
    end

    // Write data delayed two cycles so it trails the address by one after
    // the datapath stage adds its own register
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            ui_rw_n       <= 1'b1;
            ui_write_data <= '0;
        end else begin
            wr_q    <= gnt_any & ~sel_rw_n;
            ui_rw_n <= ~wr_q;
            if (gnt_any && !sel_rw_n) begin
                wdata_q <= sel_wdata;
            end
            if (wr_q) begin
                ui_write_data <= wdata_q;
            end
        end
    end

    // Tag pipe: one {valid, owner} entry per cycle, valid only for reads
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < PIPE_LEN; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0].valid <= gnt_any & sel_rw_n;
            tag_pipe[0].owner <= sel_owner;
            for (int unsigned i = 1; i < PIPE_LEN; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Return stage: capture read data and pulse the owner's rvalid
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            rdata    <= '0;
        end else begin
            a_rvalid <= tag_pipe[PIPE_LEN-1].valid && (tag_pipe[PIPE_LEN-1].owner == OWNER_A);
            b_rvalid <= tag_pipe[PIPE_LEN-1].valid && (tag_pipe[PIPE_LEN-1].owner == OWNER_B);
            if (tag_pipe[PIPE_LEN-1].valid) begin
                rdata <= ui_read_data;
            end
        end
    end

endmodule

// File: tb/tb_zbt_arbiter_f.sv
// Self-checking bench for zbt_arbiter_f: round-robin reference model,
// SRAM + datapath-stage model, and scoreboard queues for command, write
// and read-return slots.
module tb_zbt_arbiter_f;

    localparam int DW = 36;
    localparam int AW = 19;
    localparam int RL = 4;

    logic          fpga_clk;
    logic          reset_n;
    logic          a_req, b_req, a_rw_n, b_rw_n;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] sram_addr;
    logic          sram_adv_ld_n, sram_we_n, sram_ce_n, ui_rw_n;
    logic [DW-1:0] ui_write_data, ui_read_data;

    zbt_arbiter_f #(
        .DATA_BITS (DW),
        .ADDR_BITS (AW),
        .READ_LAT  (RL)
    ) dut (
        .fpga_clk      (fpga_clk),
        .reset_n       (reset_n),
        .a_req         (a_req),
        .a_rw_n        (a_rw_n),
        .a_addr        (a_addr),
        .a_wdata       (a_wdata),
        .b_req         (b_req),
        .b_rw_n        (b_rw_n),
        .b_addr        (b_addr),
        .b_wdata       (b_wdata),
        .a_gnt         (a_gnt),
        .b_gnt         (b_gnt),
        .a_rvalid      (a_rvalid),
        .b_rvalid      (b_rvalid),
        .rdata         (rdata),
        .sram_addr     (sram_addr),
        .sram_adv_ld_n (sram_adv_ld_n),
        .sram_we_n     (sram_we_n),
        .sram_ce_n     (sram_ce_n),
        .ui_rw_n       (ui_rw_n),
        .ui_write_data (ui_write_data),
        .ui_read_data  (ui_read_data)
    );

    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {int cyc; logic rw_n; logic [AW-1:0] addr;} cmd_t;
    typedef struct {int cyc; logic [DW-1:0] data;} wr_t;
    typedef struct {int cyc; logic owner; logic [DW-1:0] data;} rd_t;

    cmd_t cq[$];
    wr_t  wq[$];
    rd_t  rq[$];

    logic [DW-1:0] ref_mem  [256];
    logic [DW-1:0] sram_mem [256];
    logic [DW-1:0] p1_data;
    logic [AW-1:0] wa1;
    int            cyc = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = {28'hABC0000, 8'(i)} ^ 36'h5_0000_0000;
            sram_mem[i] = {28'hABC0000, 8'(i)} ^ 36'h5_0000_0000;
        end
    end

    always @(posedge fpga_clk) cyc <= cyc + 1;

    // SRAM array plus flow-through output and datapath-stage registers
    always @(posedge fpga_clk) begin
        if (!sram_ce_n && sram_we_n) p1_data <= sram_mem[sram_addr[7:0]];
        else                         p1_data <= '0;
        ui_read_data <= p1_data;
        wa1 <= sram_addr;
        if (!ui_rw_n) sram_mem[wa1[7:0]] <= ui_write_data;
    end

    // Monitor / scoreboard, sampled mid-cycle
    logic          prio_b_m = 1'b0;
    logic          eg_a, eg_b, s_rw;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd;
    cmd_t          c;
    wr_t           w;
    rd_t           r;

    always @(negedge fpga_clk) begin
        if (!reset_n) begin
            check("rst_a_gnt", 64'(a_gnt), 64'(0));
            check("rst_b_gnt", 64'(b_gnt), 64'(0));
            check("rst_ce_n", 64'(sram_ce_n), 64'(1));
            check("rst_adv_we", 64'({sram_adv_ld_n, sram_we_n, ui_rw_n}), 64'(3'b111));
            check("rst_rvalid", 64'({a_rvalid, b_rvalid}), 64'(0));
            check("rst_addr", 64'(sram_addr), 64'(0));
            check("rst_data", 64'(rdata | ui_write_data), 64'(0));
            cq.delete(); wq.delete(); rq.delete();
            prio_b_m = 1'b0;
        end else begin
            eg_a = a_req && (!b_req || !prio_b_m);
            eg_b = b_req && (!a_req || prio_b_m);
            check("a_gnt", 64'(a_gnt), 64'(eg_a));
            check("b_gnt", 64'(b_gnt), 64'(eg_b));
            if (eg_a || eg_b) begin
                s_rw   = eg_b ? b_rw_n  : a_rw_n;
                s_addr = eg_b ? b_addr  : a_addr;
                s_wd   = eg_b ? b_wdata : a_wdata;
                cq.push_back('{cyc + 1, s_rw, s_addr});
                if (!s_rw) begin
                    wq.push_back('{cyc + 2, s_wd});
                    ref_mem[s_addr[7:0]] = s_wd;
                end else begin
                    rq.push_back('{cyc + RL, eg_b, ref_mem[s_addr[7:0]]});
                end
                prio_b_m = eg_a;
            end
            if (cq.size() > 0 && cq[0].cyc == cyc) begin
                c = cq.pop_front();
                check("cmd_ce_adv", 64'({sram_ce_n, sram_adv_ld_n}), 64'(0));
                check("cmd_we_n", 64'(sram_we_n), 64'(c.rw_n));
                check("cmd_addr", 64'(sram_addr), 64'(c.addr));
            end else begin
                check("idle_cmd", 64'({sram_ce_n, sram_adv_ld_n, sram_we_n}), 64'(3'b111));
            end
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                w = wq.pop_front();
                check("wr_rw_n", 64'(ui_rw_n), 64'(0));
                check("wr_data", 64'(ui_write_data), 64'(w.data));
            end else begin
                check("idle_rw_n", 64'(ui_rw_n), 64'(1));
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                r = rq.pop_front();
                check("rd_valid", 64'({a_rvalid, b_rvalid}), r.owner ? 64'(2'b01) : 64'(2'b10));
                check("rd_data", 64'(rdata), 64'(r.data));
            end else begin
                check("idle_rvalid", 64'({a_rvalid, b_rvalid}), 64'(0));
            end
        end
    end

    // One cycle of stimulus, applied just after the active edge
    task automatic drv(input logic ar, input logic arw, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                       input logic br, input logic brw, input logic [AW-1:0] bad_, input logic [DW-1:0] bwd);
        a_req = ar; a_rw_n = arw; a_addr = aad; a_wdata = awd;
        b_req = br; b_rw_n = brw; b_addr = bad_; b_wdata = bwd;
        @(posedge fpga_clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 1, '0, '0, 0, 1, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        a_req = 1'b1; a_rw_n = 1'b1; a_addr = 19'h5; a_wdata = '0;
        b_req = 1'b0; b_rw_n = 1'b1; b_addr = '0;   b_wdata = '0;
        repeat (3) @(posedge fpga_clk);
        #1;
        // release with A already requesting: grant in the first cycle
        reset_n = 1'b1;
        drv(1, 1, 19'h5, '0, 0, 1, '0, '0);
        idle(3);
        // single write then read-back
        drv(1, 0, 19'h10, 36'h2A, 0, 1, '0, '0);
        idle(4);
        drv(1, 1, 19'h10, '0, 0, 1, '0, '0);
        idle(6);
        // contention: both held, fields change while waiting
        for (int i = 0; i < 6; i++) begin
            drv(1, 1, 19'h20 + 19'(i), 36'h100 + 36'(i),
                1, 1, 19'h40 + 19'(i), 36'h200 + 36'(i));
        end
        idle(6);
        // B read, A write, B read back to back
        drv(0, 1, '0, '0, 1, 1, 19'h50, '0);
        drv(1, 0, 19'h60, 36'h3C, 0, 1, '0, '0);
        drv(0, 1, '0, '0, 1, 1, 19'h51, '0);
        idle(6);
        // reads of written location and burst write addr
        drv(0, 1, '0, '0, 1, 1, 19'h60, '0);
        idle(6);
        // mid-flight reset: three reads, reset lands on the third
        drv(1, 1, 19'h30, '0, 0, 1, '0, '0);
        drv(0, 1, '0, '0, 1, 1, 19'h31, '0);
        reset_n = 1'b0;
        drv(1, 1, 19'h32, '0, 0, 1, '0, '0);
        idle(2);
        reset_n = 1'b1;
        idle(8);
        check("drain", 64'(cq.size() + wq.size() + rq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
